// File: rtl/axis_dot_product_unit.sv
// LANES-wide fixed-point dot-product engine joining AXI-Stream data (L) and weight (T) streams.
// Define DPU_SATURATE_EN to clamp the rescaled result instead of wrapping it.

module dpu_lane_mul #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [A_W-1:0]    a,
    input  logic signed [B_W-1:0]    b,
    output logic signed [A_W+B_W-1:0] prod_q
);
    logic signed [A_W+B_W-1:0] prod_d;

    always_comb begin
        prod_d = prod_q;
        if (en) prod_d = (A_W+B_W)'(a) * (A_W+B_W)'(b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod_q <= '0;
        else        prod_q <= prod_d;
    end
endmodule

module axis_dot_product_unit #(
    parameter int LANES                = 4,
    parameter int OP0_WIDTH            = 16,
    parameter int OP0_FRACTIONAL_BITS  = 12,
    parameter int OP1_WIDTH            = 16,
    parameter int OP1_FRACTIONAL_BITS  = 12,
    parameter int RSLT_WIDTH           = 16,
    parameter int RSLT_FRACTIONAL_BITS = 12,
    parameter int ACC_WIDTH            = OP0_WIDTH + OP1_WIDTH + $clog2(LANES) + 8,
    parameter int ID_WIDTH             = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES*OP0_WIDTH-1:0]   s_axis_l_tdata,
    input  logic                         s_axis_l_tvalid,
    output logic                         s_axis_l_tready,
    input  logic                         s_axis_l_tlast,
    input  logic [ID_WIDTH-1:0]          s_axis_l_tid,
    input  logic [LANES*OP1_WIDTH-1:0]   s_axis_t_tdata,
    input  logic                         s_axis_t_tvalid,
    output logic                         s_axis_t_tready,
    input  logic                         s_axis_t_tlast,
    output logic [RSLT_WIDTH-1:0]        m_axis_d_tdata,
    output logic                         m_axis_d_tvalid,
    input  logic                         m_axis_d_tready,
    output logic                         m_axis_d_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_d_tid,
    output logic                         err_unalligned_data
);
    localparam int PW    = OP0_WIDTH + OP1_WIDTH;
    localparam int SHIFT = OP0_FRACTIONAL_BITS + OP1_FRACTIONAL_BITS - RSLT_FRACTIONAL_BITS;

    typedef enum logic [1:0] {ACCUM, FLUSH, OUTPUT} state_t;

    state_t                       state_q, state_d;
    logic                         flush_cnt_q, flush_cnt_d;
    logic                         run_q;
    logic                         first_q, first_d;
    logic [ID_WIDTH-1:0]          tid_q, tid_d;
    logic [1:0]                   vld_pipe_q, vld_pipe_d;
    logic [1:0]                   last_pipe_q, last_pipe_d;
    logic                         first_s1_q, first_s1_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         out_vld_q, out_vld_d;
    logic [RSLT_WIDTH-1:0]        out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]          out_tid_q, out_tid_d;
    logic                         err_q, err_d;

    logic                         accept, beat_last;
    logic [LANES-1:0][PW-1:0]     prod_q;
    logic signed [ACC_WIDTH-1:0]  lane_sum;
    logic signed [ACC_WIDTH-1:0]  scaled;
    logic [RSLT_WIDTH-1:0]        rslt;

    // run_q keeps both treadys low while reset is asserted (state resets to ACCUM).
    assign accept          = run_q && (state_q == ACCUM) && s_axis_l_tvalid && s_axis_t_tvalid;
    assign beat_last       = s_axis_l_tlast | s_axis_t_tlast;
    assign s_axis_l_tready = accept;
    assign s_axis_t_tready = accept;

    // S1: one registered product per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dpu_lane_mul #(.A_W(OP0_WIDTH), .B_W(OP1_WIDTH)) u_mul (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (accept),
            .a      (s_axis_l_tdata[k*OP0_WIDTH +: OP0_WIDTH]),
            .b      (s_axis_t_tdata[k*OP1_WIDTH +: OP1_WIDTH]),
            .prod_q (prod_q[k])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++)
            lane_sum = lane_sum + {{(ACC_WIDTH-PW){prod_q[k][PW-1]}}, prod_q[k]};
    end

    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACC_WIDTH-1:0] RND_BIAS = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT-1);
        logic signed [ACC_WIDTH-1:0] biased;
        assign biased = acc_q + RND_BIAS;
        assign scaled = biased >>> SHIFT;
    end else begin : g_noround
        assign scaled = acc_q;
    end

`ifdef DPU_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] RMAX = {{(ACC_WIDTH-RSLT_WIDTH+1){1'b0}}, {(RSLT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RMIN = {{(ACC_WIDTH-RSLT_WIDTH+1){1'b1}}, {(RSLT_WIDTH-1){1'b0}}};
    always_comb begin
        rslt = scaled[RSLT_WIDTH-1:0];
        if (scaled > RMAX)      rslt = RMAX[RSLT_WIDTH-1:0];
        else if (scaled < RMIN) rslt = RMIN[RSLT_WIDTH-1:0];
    end
`else
    logic unused_hi;
    assign rslt      = scaled[RSLT_WIDTH-1:0];
    assign unused_hi = ^scaled[ACC_WIDTH-1:RSLT_WIDTH];
`endif

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ACCUM: if (accept && beat_last) begin
                state_d     = FLUSH;
                flush_cnt_d = 1'b0;
            end
            FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) state_d = OUTPUT;
            end
            OUTPUT: if (out_vld_q && m_axis_d_tready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        first_d     = first_q;
        tid_d       = tid_q;
        if (accept) begin
            first_d = beat_last;
            if (first_q) tid_d = s_axis_l_tid;
        end
        vld_pipe_d  = {vld_pipe_q[0], accept};
        last_pipe_d = {last_pipe_q[0], accept & beat_last};
        first_s1_d  = accept & first_q;
        err_d       = accept & (s_axis_l_tlast ^ s_axis_t_tlast);

        // S2: first beat of a vector loads, later beats accumulate
        acc_d = acc_q;
        if (vld_pipe_q[0]) acc_d = first_s1_q ? lane_sum : acc_q + lane_sum;

        // S3: output register holds until the D handshake
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_tid_d  = out_tid_q;
        if (out_vld_q && m_axis_d_tready) out_vld_d = 1'b0;
        if (vld_pipe_q[1] && last_pipe_q[1]) begin
            out_vld_d  = 1'b1;
            out_data_d = rslt;
            out_tid_d  = tid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            flush_cnt_q <= 1'b0;
            run_q       <= 1'b0;
            first_q     <= 1'b1;
            tid_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            first_s1_q  <= 1'b0;
            acc_q       <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= 1'b1;
            first_q     <= first_d;
            tid_q       <= tid_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            first_s1_q  <= first_s1_d;
            acc_q       <= acc_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_tid_q   <= out_tid_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_d_tdata      = out_data_q;
    assign m_axis_d_tvalid     = out_vld_q;
    assign m_axis_d_tlast      = out_vld_q;
    assign m_axis_d_tid        = out_tid_q;
    assign err_unalligned_data = err_q;
endmodule
